// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding and PC constants.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_INC   = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, instr} holding register that catches a response arriving while IF/ID is stalled.
module if_skid_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads and fills the IF/ID slot.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_INC   = DEFAULT_PC_INC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [1:0]  dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, addr_q;
  logic         issue, accept, flush, unload;
  logic         slot_load, skid_load;
  logic         skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  // imem handshake: imem_req_o stays high with imem_addr_o stable until the
  // cycle imem_ready_i=1 completes it; a request is never withdrawn.
  assign imem_req_o  = (state_q != ST_FETCH);
  assign imem_addr_o = addr_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    flush   = 1'b0;
    unload  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (redirect_valid_i) begin
          flush = 1'b1;
        end else if (skid_valid) begin
          // Draining the skid takes this cycle; fetch resumes on the next one.
          unload = !stall_i;
        end else if (!stall_i || !if_valid_o) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid_i) begin
          flush   = 1'b1;
          state_d = imem_ready_i ? ST_FETCH : ST_DROP;
        end else if (imem_ready_i) begin
          accept = 1'b1;
          issue  = !stall_i;
          state_d = stall_i ? ST_FETCH : ST_WAIT;
        end
      end
      ST_DROP: begin
        flush = redirect_valid_i;
        if (imem_ready_i) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign slot_load = accept && (!stall_i || !if_valid_o);
  assign skid_load = accept && stall_i && if_valid_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      if (flush)       pc_q <= word_align(redirect_pc_i);
      else if (accept) pc_q <= addr_q + PC_INC;
      // Back-to-back issue happens before pc_q catches up, so use addr_q directly.
      if (issue) addr_q <= (state_q == ST_WAIT) ? addr_q + PC_INC : pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_o    <= 1'b0;
      if_pc_o       <= '0;
      if_instr_o    <= NOP_INSTR;
      if_pc_plus4_o <= '0;
    end else if (flush) begin
      if_valid_o <= 1'b0;
    end else if (slot_load) begin
      if_valid_o    <= 1'b1;
      if_pc_o       <= addr_q;
      if_instr_o    <= imem_rdata_i;
      if_pc_plus4_o <= addr_q + PC_INC;
    end else if (unload) begin
      if_valid_o    <= 1'b1;
      if_pc_o       <= skid_pc;
      if_instr_o    <= skid_instr;
      if_pc_plus4_o <= skid_pc + PC_INC;
    end
  end

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .unload   (unload),
    .clear    (flush),
    .pc_in    (addr_q),
    .instr_in (imem_rdata_i),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model, randomized stall/redirect/ready, stream-level scoreboard.
module tb_if_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o, if_instr_o, if_pc_plus4_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int outputs_seen = 0;

  // Model state: expected delivered {pc, instr}, next address the stream must fetch,
  // and whether the outstanding request belongs to a stream killed by a redirect.
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch = RESET_PC;
  logic        taint = 1'b0;
  logic        prev_valid, prev_stall, prev_redirect, prev_req, prev_ready;
  logic [31:0] prev_addr, prev_pc, prev_instr, prev_pc4;

  if_fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(32'd4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_ready_i     (imem_ready_i),
    .imem_rdata_i     (imem_rdata_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o),
    .if_pc_plus4_o    (if_pc_plus4_o),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata_i = imem_ready_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc);
    stall_i          = st;
    imem_ready_i     = rdy;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!imem_req_o && n < 50) begin
      step();
      n++;
    end
    check(name, {31'b0, imem_req_o}, 32'd1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_fetch = RESET_PC;
        taint = 1'b0;
        prev_valid = 1'b0; prev_stall = 1'b0; prev_redirect = 1'b0;
        prev_req = 1'b0; prev_ready = 1'b0; prev_addr = RESET_PC;
        prev_pc = '0; prev_instr = '0; prev_pc4 = '0;
      end else begin
        if (prev_redirect) begin
          check("flush_valid", {31'b0, if_valid_o}, 32'd0);
        end else if (prev_stall && prev_valid) begin
          check("hold_valid", {31'b0, if_valid_o}, 32'd1);
          check("hold_pc", if_pc_o, prev_pc);
          check("hold_instr", if_instr_o, prev_instr);
          check("hold_pc4", if_pc_plus4_o, prev_pc4);
        end
        if (imem_req_o && !prev_req)
          check("issue_gate", {31'b0, (!prev_stall || !prev_valid)}, 32'd1);
        if (prev_req && !prev_ready) begin
          check("req_held", {31'b0, imem_req_o}, 32'd1);
          check("addr_held", imem_addr_o, prev_addr);
        end
        if (if_valid_o && (!prev_valid || if_pc_o != prev_pc)) begin
          outputs_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected actual pc=%h required=no output", if_pc_o);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", if_pc_o, e[63:32]);
            check("out_instr", if_instr_o, e[31:0]);
            check("out_pc4", if_pc_plus4_o, e[63:32] + 32'd4);
          end
        end
        // Reference stream update for the edge about to come.
        if (redirect_valid_i) begin
          exp_q.delete();
          exp_fetch = redirect_pc_i & ~32'h3;
          taint = imem_req_o && !imem_ready_i;
        end else if (imem_req_o && imem_ready_i) begin
          if (!taint) begin
            check("fetch_addr", imem_addr_o, exp_fetch);
            exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
          end
          taint = 1'b0;
        end
        prev_valid = if_valid_o; prev_stall = stall_i; prev_redirect = redirect_valid_i;
        prev_req = imem_req_o; prev_ready = imem_ready_i; prev_addr = imem_addr_o;
        prev_pc = if_pc_o; prev_instr = if_instr_o; prev_pc4 = if_pc_plus4_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check("rst_valid", {31'b0, if_valid_o}, 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_instr", if_instr_o, NOP_INSTR);
    check("rst_pc4", if_pc_plus4_o, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});

    // Zero-wait memory: one request per cycle from RESET_PC.
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_req", {31'b0, imem_req_o}, 32'd1);
      check("seq_addr", imem_addr_o, RESET_PC + 32'(k * 4));
      check("seq_valid", {31'b0, if_valid_o}, (k >= 1) ? 32'd1 : 32'd0);
    end

    // Wait states on the current request.
    set_in(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();
    set_in(1'b0, 1'b1, 1'b0, '0);
    step();

    // Stall with a response in flight: it lands in the skid.
    set_in(1'b1, 1'b1, 1'b0, '0);
    step();
    set_in(1'b1, 1'b0, 1'b0, '0);
    repeat (4) step();
    set_in(1'b0, 1'b1, 1'b0, '0);
    repeat (4) step();

    // Redirect while a request waits.
    set_in(1'b0, 1'b0, 1'b0, '0);
    wait_req("wait_req_redir");
    set_in(1'b0, 1'b0, 1'b1, 32'h0000_0400);
    step();
    set_in(1'b0, 1'b0, 1'b0, '0);
    repeat (2) step();
    set_in(1'b0, 1'b1, 1'b0, '0);
    repeat (5) step();

    // Redirect to an unaligned target coincident with ready and stall.
    set_in(1'b0, 1'b0, 1'b0, '0);
    wait_req("wait_req_coinc");
    set_in(1'b1, 1'b1, 1'b1, 32'h0000_0403);
    step();
    set_in(1'b1, 1'b0, 1'b0, '0);
    wait_req("wait_req_target");
    check("coinc_target", imem_addr_o, 32'h0000_0400);
    set_in(1'b0, 1'b1, 1'b0, '0);
    repeat (3) step();

    // Sequential fetch across the top of the address space.
    set_in(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step();
    set_in(1'b0, 1'b1, 1'b0, '0);
    repeat (8) step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(99) < 30, $urandom_range(99) < 60,
             $urandom_range(99) < 4, $urandom());
      step();
    end

    // Asynchronous reset in the middle of an outstanding request.
    set_in(1'b0, 1'b0, 1'b0, '0);
    wait_req("wait_req_rst");
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req_o}, 32'd0);
    check("arst_addr", imem_addr_o, RESET_PC);
    check("arst_valid", {31'b0, if_valid_o}, 32'd0);
    check("arst_pc", if_pc_o, 32'd0);
    check("arst_instr", if_instr_o, NOP_INSTR);
    check("arst_pc4", if_pc_plus4_o, 32'd0);
    check("arst_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    imem_ready_i = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    wait_req("wait_req_post_rst");
    check("post_rst_addr", imem_addr_o, RESET_PC);
    repeat (6) step();

    // Drain: every accepted response must have reached the output.
    set_in(1'b0, 1'b0, 1'b0, '0);
    repeat (4) step();
    check("drain_empty", exp_q.size(), 32'd0);
    check("progress", {31'b0, (outputs_seen > 100)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
